// File: rtl/filo_ctrl.sv
// Command-side controller for a LIFO stack: turns push/pop/peek/drain commands
// into stack strobes and returns results on a valid/ready response port.
module filo_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [DATA_W-1:0]          cmd_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_err,
  output logic                       rsp_last,
  output logic                       stk_en,
  output logic                       stk_read_write,
  output logic [DATA_W-1:0]          stk_data_in,
  input  logic [DATA_W-1:0]          stk_data_out,
  input  logic                       stk_empty,
  input  logic                       stk_full,
  input  logic [$clog2(DEPTH)+1:0]   stk_last
);

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_DRAIN = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    REPUSH = 3'd3,
    WAIT2  = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t              state_r;
  state_t              next_s;
  logic [1:0]          op_r;
  logic [DATA_W-1:0]   data_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic                rsp_err_r;
  logic                rsp_last_r;
  logic                first_r;
  logic                err_s;
  logic                en_s;
  logic                rw_s;
  logic [DATA_W-1:0]   din_s;

  // Error decision from the flags seen in ISSUE; drain only errors on its first pass
  always_comb begin
    err_s = 1'b0;
    case (op_r)
      OP_PUSH:  err_s = stk_full;
      OP_POP:   err_s = stk_empty;
      OP_PEEK:  err_s = stk_empty;
      OP_DRAIN: err_s = stk_empty & first_r;
      default:  err_s = 1'b0;
    endcase
  end

  // Next-state and stack strobe decode
  always_comb begin
    next_s = state_r;
    en_s   = 1'b0;
    rw_s   = 1'b0;
    din_s  = '0;
    case (state_r)
      IDLE: begin
        if (cmd_valid) next_s = ISSUE;
        else           next_s = IDLE;
      end
      ISSUE: begin
        if (err_s) begin
          next_s = RESP;
        end else begin
          en_s   = 1'b1;
          next_s = WAIT;
          if (op_r == OP_PUSH) begin
            rw_s  = 1'b0;
            din_s = data_r;
          end else begin
            rw_s  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (op_r == OP_PEEK) next_s = REPUSH;
        else                 next_s = RESP;
      end
      REPUSH: begin
        en_s   = 1'b1;
        rw_s   = 1'b0;
        din_s  = rsp_data_r;
        next_s = WAIT2;
      end
      WAIT2: next_s = RESP;
      RESP: begin
        if (!rsp_ready)                            next_s = RESP;
        else if (op_r == OP_DRAIN && !rsp_last_r)  next_s = ISSUE;
        else                                       next_s = IDLE;
      end
      default: next_s = IDLE;
    endcase
  end

  // State register plus command and response latches
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      op_r       <= 2'b00;
      data_r     <= '0;
      rsp_data_r <= '0;
      rsp_err_r  <= 1'b0;
      rsp_last_r <= 1'b0;
      first_r    <= 1'b0;
    end else begin
      state_r <= next_s;
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            op_r    <= cmd_op;
            data_r  <= cmd_data;
            first_r <= 1'b1;
          end
        end
        ISSUE: begin
          rsp_last_r <= 1'b1;
          if (err_s) begin
            rsp_err_r  <= 1'b1;
            rsp_data_r <= '0;
          end else begin
            rsp_err_r <= 1'b0;
            if (op_r == OP_PUSH) rsp_data_r <= data_r;
          end
        end
        WAIT: begin
          first_r <= 1'b0;
          if (op_r != OP_PUSH) rsp_data_r <= stk_data_out;
          // a drain word is final once this pop has emptied the stack
          if (op_r == OP_DRAIN) rsp_last_r <= (stk_last == '0);
        end
        default: begin
        end
      endcase
    end
  end

  // Reset gates the strobe-side outputs so an abort never reaches the stack
  assign cmd_ready      = (state_r == IDLE) && !reset;
  assign rsp_valid      = (state_r == RESP) && !reset;
  assign stk_en         = en_s && !reset;
  assign stk_read_write = rw_s && !reset;
  assign stk_data_in    = reset ? '0 : din_s;
  assign rsp_data       = rsp_data_r;
  assign rsp_err        = rsp_err_r;
  assign rsp_last       = rsp_last_r;

endmodule

// File: tb/tb_filo_ctrl.sv
// Scoreboard bench for filo_ctrl with a behavioural 16-entry stack model.
module tb_filo_ctrl;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_DRAIN = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_data = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_last;
  logic        stk_en;
  logic        stk_read_write;
  logic [31:0] stk_data_in;
  logic [31:0] stk_data_out;
  logic        stk_empty;
  logic        stk_full;
  logic [5:0]  stk_last;

  always #5 clk = ~clk;

  filo_ctrl #(.DATA_W(32), .DEPTH(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_last(rsp_last),
    .stk_en(stk_en), .stk_read_write(stk_read_write), .stk_data_in(stk_data_in),
    .stk_data_out(stk_data_out), .stk_empty(stk_empty), .stk_full(stk_full),
    .stk_last(stk_last)
  );

  // Stack model: flags and read data change on the edge of the strobe
  logic [31:0] mem [16];
  logic [5:0]  cnt = 6'd0;
  logic [31:0] sdout = 32'h0;
  always @(posedge clk) begin
    if (stk_en) begin
      if (!stk_read_write) begin
        if (cnt < 6'd16) begin
          mem[cnt[3:0]] <= stk_data_in;
          cnt <= cnt + 6'd1;
        end
      end else if (cnt != 6'd0) begin
        sdout <= mem[cnt[3:0] - 4'd1];
        cnt   <= cnt - 6'd1;
      end
    end
  end
  assign stk_empty    = (cnt == 6'd0);
  assign stk_full     = (cnt == 6'd16);
  assign stk_last     = cnt;
  assign stk_data_out = sdout;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        last;
    int          lat;
  } exp_t;

  exp_t q[$];
  logic slog[$];
  int   errors = 0;
  int   checks = 0;
  int   strobes = 0;
  int   stall = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_rsp(input logic [31:0] d, input logic e, input logic l, input int lat);
    exp_t x;
    x.data = d; x.err = e; x.last = l; x.lat = lat;
    q.push_back(x);
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] d);
    int n;
    @(posedge clk); #1;
    cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_ready timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((q.size() != 0 || !cmd_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || !cmd_ready) chk("idle timeout", 64'd0, 64'd1);
  endtask

  // Monitor: latency of each response, held contents, and handshake pops
  initial begin : monitor
    int   ref_cyc;
    int   vcnt;
    logic in_rsp;
    exp_t e;
    ref_cyc = 0; vcnt = 0; in_rsp = 1'b0;
    forever begin
      @(negedge clk);
      if (stk_en) begin
        strobes++;
        slog.push_back(stk_read_write);
      end
      if (reset) begin
        in_rsp = 1'b0; vcnt = 0; rsp_ready = (stall == 0);
      end else begin
        if (cmd_valid && cmd_ready) ref_cyc = cyc;
        if (rsp_valid) begin
          vcnt++;
          rsp_ready = (vcnt > stall);
          if (q.size() == 0) begin
            chk("unexpected rsp", {31'd0, rsp_data, rsp_err, rsp_last}, 64'd0);
          end else begin
            e = q[0];
            if (!in_rsp) chk("rsp latency", 64'(cyc - ref_cyc), 64'(e.lat));
            in_rsp = 1'b1;
            chk("rsp {data,err,last}", {30'd0, rsp_data, rsp_err, rsp_last},
                {30'd0, e.data, e.err, e.last});
            if (rsp_ready) begin
              void'(q.pop_front());
              in_rsp = 1'b0; vcnt = 0; ref_cyc = cyc;
            end
          end
        end else begin
          vcnt = 0; in_rsp = 1'b0; rsp_ready = (stall == 0);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int s0;
    reset = 1'b1; cmd_valid = 1'b1; cmd_op = OP_PUSH; cmd_data = 32'h55;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset cmd_ready", 64'(cmd_ready), 64'd0);
      chk("reset rsp", {30'd0, rsp_data, rsp_err, rsp_last, rsp_valid}, 64'd0);
      chk("reset stk", {31'd0, stk_data_in, stk_en, stk_read_write}, 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    chk("cmd_ready after reset", 64'(cmd_ready), 64'd1);
    chk("no strobe in reset", 64'(strobes), 64'd0);

    // push three then pop three
    expect_rsp(32'h11, 1'b0, 1'b1, 3); send(OP_PUSH, 32'h11);
    expect_rsp(32'h22, 1'b0, 1'b1, 3); send(OP_PUSH, 32'h22);
    expect_rsp(32'h33, 1'b0, 1'b1, 3); send(OP_PUSH, 32'h33);
    expect_rsp(32'h33, 1'b0, 1'b1, 3); send(OP_POP, 32'h0);
    expect_rsp(32'h22, 1'b0, 1'b1, 3); send(OP_POP, 32'h0);
    expect_rsp(32'h11, 1'b0, 1'b1, 3); send(OP_POP, 32'h0);
    wait_idle();
    chk("stk_last after pops", 64'(stk_last), 64'd0);

    // pop on empty
    s0 = strobes;
    expect_rsp(32'h0, 1'b1, 1'b1, 2); send(OP_POP, 32'h0);
    wait_idle();
    chk("empty pop strobes", 64'(strobes - s0), 64'd0);

    // fill, overflow, peek at full
    for (int i = 0; i < 16; i++) begin
      expect_rsp(32'h100 + 32'(i), 1'b0, 1'b1, 3);
      send(OP_PUSH, 32'h100 + 32'(i));
    end
    wait_idle();
    chk("stk_last full", 64'(stk_last), 64'd16);
    s0 = strobes;
    expect_rsp(32'h0, 1'b1, 1'b1, 2); send(OP_PUSH, 32'hDEAD);
    wait_idle();
    chk("overflow strobes", 64'(strobes - s0), 64'd0);
    s0 = strobes;
    expect_rsp(32'h10F, 1'b0, 1'b1, 5); send(OP_PEEK, 32'h0);
    wait_idle();
    chk("peek strobes", 64'(strobes - s0), 64'd2);
    chk("peek pop-then-push", {62'd0, slog[slog.size()-2], slog[slog.size()-1]}, 64'd2);
    chk("stk_last after peek", 64'(stk_last), 64'd16);

    // drain all sixteen at full speed
    for (int i = 15; i >= 0; i--) expect_rsp(32'h100 + 32'(i), 1'b0, (i == 0), 3);
    send(OP_DRAIN, 32'h0);
    wait_idle();
    chk("empty after drain16", 64'(stk_empty), 64'd1);

    // drain three with a four-cycle stall on each word
    expect_rsp(32'hA1, 1'b0, 1'b1, 3); send(OP_PUSH, 32'hA1);
    expect_rsp(32'hA2, 1'b0, 1'b1, 3); send(OP_PUSH, 32'hA2);
    expect_rsp(32'hA3, 1'b0, 1'b1, 3); send(OP_PUSH, 32'hA3);
    wait_idle();
    stall = 4;
    expect_rsp(32'hA3, 1'b0, 1'b0, 3);
    expect_rsp(32'hA2, 1'b0, 1'b0, 3);
    expect_rsp(32'hA1, 1'b0, 1'b1, 3);
    send(OP_DRAIN, 32'h0);
    wait_idle();
    stall = 0;
    chk("empty after stalled drain", 64'(stk_empty), 64'd1);

    // reset while a drain sits in WAIT
    expect_rsp(32'hB1, 1'b0, 1'b1, 3); send(OP_PUSH, 32'hB1);
    expect_rsp(32'hB2, 1'b0, 1'b1, 3); send(OP_PUSH, 32'hB2);
    wait_idle();
    s0 = strobes;
    send(OP_DRAIN, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    chk("abort drain popped once", 64'(strobes - s0), 64'd1);
    s0 = strobes;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rsp_valid after abort", 64'(rsp_valid), 64'd0);
    chk("no strobe after abort", 64'(strobes - s0), 64'd0);
    chk("stk_last after abort", 64'(stk_last), 64'd1);
    expect_rsp(32'hB1, 1'b0, 1'b1, 3); send(OP_POP, 32'h0);
    wait_idle();
    chk("stk_last end", 64'(stk_last), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
